mux_nx1_pipe: RTL and testbench
===============================

MUX_NX1_PIPE -- requirements
Module: mux_nx1_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each input and of the output.
REQ-002 SHALL have parameter NUM_IN, default 4, number of data inputs, legal range 2..16.
REQ-003 SHALL have parameter SEL_W, default 2, select width, with the requirement that 2**SEL_W >= NUM_IN.
REQ-004 SHALL have parameter DEFAULT_VAL, default 32'd0, the value output when the select is out of range.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_data, input, NUM_IN*WIDTH bits: input k occupies bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port in_sel, input, SEL_W bits: input index, sampled with in_valid.
REQ-009 SHALL have port in_valid, input, 1 bit: the source offers a request.
REQ-010 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-011 SHALL have port out_data, output, WIDTH bits: the selected word.
REQ-012 SHALL have port out_sel, output, SEL_W bits: the select that produced out_data.
REQ-013 SHALL have port out_valid, output, 1 bit: out_data and out_sel are valid.
REQ-014 SHALL have port out_ready, input, 1 bit: the sink accepts the output.
REQ-015 SHALL have port err_sel, output, 1 bit, present only with MUX_NX1_PIPE_ERR_EN: the current output came from an out-of-range select.
REQ-016 SHALL have port err_cnt, output, 8 bits, present only with MUX_NX1_PIPE_ERR_EN: saturating count of out-of-range accepts.

Function
REQ-017 SHALL accept a request on a rising clk edge when in_valid=1 and in_ready=1.
REQ-018 SHALL, on accept, capture word in_data[in_sel*WIDTH +: WIDTH], or DEFAULT_VAL if in_sel >= NUM_IN, together with in_sel, so that the inputs need not be held afterwards.
REQ-019 SHALL buffer captured entries in a 2-entry FIFO (skid buffer) and deliver them in accept order.
REQ-020 SHALL drive in_ready = 1 exactly when fewer than 2 entries are held; in_ready SHALL be registered and SHALL NOT depend combinationally on out_ready.
REQ-021 SHALL drive out_valid = 1 whenever at least 1 entry is held; out_data and out_sel SHALL show the oldest entry.
REQ-022 SHALL retire the oldest entry on an edge where out_valid=1 and out_ready=1.
REQ-023 SHALL have a latency of 1 cycle when empty: out_valid rises on the edge that accepts the request.
REQ-024 SHALL sustain 1 transfer per cycle when out_ready is held at 1.
REQ-025 SHALL keep the count at 1 when an accept and a retire occur on the same edge with 1 entry held, so that the new entry becomes the head.
REQ-026 SHALL keep out_data, out_sel and out_valid stable while out_valid=1 and out_ready=0.
REQ-027 SHALL ignore in_valid while in_ready=0, with no state change.
REQ-028 SHALL NOT accept any request while held at 2 entries, even if a retire occurs on the same edge; in_ready SHALL rise on the following cycle.
REQ-029 SHALL update the occupancy counter and the read/write pointers modulo 2 with no overflow or underflow.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously clear the FIFO, giving in_ready=0, out_valid=0, out_data=0, out_sel=0, err_sel=0 and err_cnt=0.
REQ-031 SHALL drive in_ready=1 on the first clk edge after rst_n deasserts.
REQ-032 SHALL, when reset asserts mid-operation, discard held entries without delivering them.

Configuration
REQ-033 SHALL compile the error-tracking logic in only when macro MUX_NX1_PIPE_ERR_EN is defined.
REQ-034 SHALL, with MUX_NX1_PIPE_ERR_EN defined, store an error bit with each entry and present it on err_sel alongside out_data.
REQ-035 SHALL, with MUX_NX1_PIPE_ERR_EN defined, increment err_cnt by 1 per out-of-range accept and saturate it at 255.
REQ-036 SHALL, without MUX_NX1_PIPE_ERR_EN, omit err_sel, err_cnt and the per-entry error bit, with all other behaviour unchanged.

Verification
REQ-037 SHALL cover single transfer: empty block, in_data inputs = {0x44,0x33,0x22,0x11}, sel=2, out_ready=1 -> next cycle out_valid=1, out_data=0x33, out_sel=2.
REQ-038 SHALL cover back-pressure: out_ready=0, accept sel=0, then sel=1, then offer sel=3 -> in_ready=0 after 2 accepts; after out_ready=1, outputs are 0x11 then 0x22 in order, with no loss.
REQ-039 SHALL cover streaming: out_ready=1, 100 random valid requests on consecutive cycles -> 100 outputs in order, 1 per cycle, in_ready constant 1.
REQ-040 SHALL cover out-of-range select: NUM_IN=3, SEL_W=2, sel=3 -> out_data=DEFAULT_VAL; with MUX_NX1_PIPE_ERR_EN, err_sel=1 and err_cnt=1, and 300 such accepts -> err_cnt=255.
REQ-041 SHALL cover reset mid-flight: 2 entries held, rst_n pulsed low between edges -> out_valid=0 immediately, in_ready=0, and no stale data after release.

Source files
------------

// File: rtl/mux_nx1_pipe.sv
// N:1 word multiplexer feeding a 2-entry skid FIFO, with a registered in_ready and valid/ready on both sides.
// Optional out-of-range select tracking (err_sel, err_cnt) is compiled in with MUX_NX1_PIPE_ERR_EN.
module mux_nx1_pipe #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_IN      = 4,
    parameter int               SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = {WIDTH{1'b0}}
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_NX1_PIPE_ERR_EN
    ,
    output logic                    err_sel,
    output logic [7:0]              err_cnt
`endif
);

    logic [WIDTH-1:0] mem_data_q [2];
    logic [WIDTH-1:0] mem_data_d [2];
    logic [SEL_W-1:0] mem_sel_q  [2];
    logic [SEL_W-1:0] mem_sel_d  [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             accept_s, retire_s, sel_oor_s;
    logic [WIDTH-1:0] sel_word_s;

    // Word selection; an index with no matching input yields DEFAULT_VAL.
    always_comb begin
        sel_word_s = DEFAULT_VAL;
        sel_oor_s  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            sel_word_s = (in_sel == SEL_W'(k)) ? in_data[k*WIDTH +: WIDTH] : sel_word_s;
            sel_oor_s  = (in_sel == SEL_W'(k)) ? 1'b0 : sel_oor_s;
        end
    end

    // FIFO next state. in_ready is taken from the registered copy, so a full FIFO never accepts.
    always_comb begin
        accept_s  = in_valid & in_ready_q;
        retire_s  = out_valid_q & out_ready;
        wr_ptr_d  = wr_ptr_q ^ accept_s;
        rd_ptr_d  = rd_ptr_q ^ retire_s;
        count_d   = count_q + {1'b0, accept_s} - {1'b0, retire_s};
        mem_data_d = mem_data_q;
        mem_sel_d  = mem_sel_q;
        if (accept_s) begin
            mem_data_d[wr_ptr_q] = sel_word_s;
            mem_sel_d[wr_ptr_q]  = in_sel;
        end else begin
            mem_data_d = mem_data_q;
            mem_sel_d  = mem_sel_q;
        end
        in_ready_d  = (count_d != 2'd2);
        out_valid_d = (count_d != 2'd0);
    end

    // FIFO state registers; in_ready stays low during reset and rises on the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_data_q[0] <= {WIDTH{1'b0}};
            mem_data_q[1] <= {WIDTH{1'b0}};
            mem_sel_q[0]  <= {SEL_W{1'b0}};
            mem_sel_q[1]  <= {SEL_W{1'b0}};
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            mem_data_q  <= mem_data_d;
            mem_sel_q   <= mem_sel_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = mem_data_q[rd_ptr_q];
    assign out_sel   = mem_sel_q[rd_ptr_q];

`ifdef MUX_NX1_PIPE_ERR_EN
    logic       mem_err_q [2];
    logic       mem_err_d [2];
    logic [7:0] err_cnt_q, err_cnt_d;

    // Per-entry error flag and saturating count of out-of-range accepts.
    always_comb begin
        mem_err_d = mem_err_q;
        err_cnt_d = err_cnt_q;
        if (accept_s) begin
            mem_err_d[wr_ptr_q] = sel_oor_s;
            err_cnt_d = (sel_oor_s && (err_cnt_q != 8'd255)) ? (err_cnt_q + 8'd1) : err_cnt_q;
        end else begin
            mem_err_d = mem_err_q;
            err_cnt_d = err_cnt_q;
        end
    end

    // Error tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err_q[0] <= 1'b0;
            mem_err_q[1] <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            mem_err_q <= mem_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_sel = mem_err_q[rd_ptr_q];
    assign err_cnt = err_cnt_q;
`else
    logic unused_oor_s;
    assign unused_oor_s = sel_oor_s;
`endif

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Scoreboard bench for mux_nx1_pipe: accepts push the expected word, a monitor pops on every output transfer.
// Built with NUM_IN=3 so select 3 is out of range; err ports are checked when MUX_NX1_PIPE_ERR_EN is defined.
module tb_mux_nx1_pipe;
    localparam int          W   = 32;
    localparam int          N   = 3;
    localparam int          SW  = 2;
    localparam logic [W-1:0] DEF = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N*W-1:0] in_data;
    logic [SW-1:0] in_sel;
    logic          in_valid, in_ready;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_sel;
    logic          out_valid, out_ready;
`ifdef MUX_NX1_PIPE_ERR_EN
    logic          err_sel;
    logic [7:0]    err_cnt;
`endif

    typedef struct {
        logic [W-1:0]  d;
        logic [SW-1:0] s;
        logic          e;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   n_retired   = 0;
    int   model_err   = 0;

    mux_nx1_pipe #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .DEFAULT_VAL(DEF)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_NX1_PIPE_ERR_EN
        , .err_sel(err_sel), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a request offered while in_ready is high is taken on the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && in_valid && in_ready) begin
            e.s = in_sel;
            if (int'(in_sel) < N) begin
                e.d = in_data[int'(in_sel)*W +: W];
                e.e = 1'b0;
            end else begin
                e.d = DEF;
                e.e = 1'b1;
                if (model_err < 255) model_err++;
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: every output transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_retired++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output: got data %0h sel %0d, expected no output", out_data, out_sel);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 64'(out_data), 64'(e.d));
                check("out_sel", 64'(out_sel), 64'(e.s));
`ifdef MUX_NX1_PIPE_ERR_EN
                check("err_sel", 64'(err_sel), 64'(e.e));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_sel = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sel", 64'(out_sel), 64'd0);
`ifdef MUX_NX1_PIPE_ERR_EN
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
        rst_n = 1'b1;
        #1 check("in_ready_before_edge", 64'(in_ready), 64'd0);
        step();
        check("in_ready_first_edge", 64'(in_ready), 64'd1);

        // Single transfer, one-cycle latency.
        in_data = {32'h33, 32'h22, 32'h11}; in_sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_data", 64'(out_data), 64'h33);
        check("single_sel", 64'(out_sel), 64'd2);
        step();
        check("single_empty", 64'(out_valid), 64'd0);

        // Back-pressure: fill, stall, then full-with-retire does not accept.
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
        step();
        in_sel = 2'd1;
        step();
        check("bp_full_ready", 64'(in_ready), 64'd0);
        check("bp_head", 64'(out_data), 64'h11);
        in_sel = 2'd3;
        step();
        check("bp_stall_ready", 64'(in_ready), 64'd0);
        check("bp_stall_data", 64'(out_data), 64'h11);
        check("bp_stall_sel", 64'(out_sel), 64'd0);
        check("bp_stall_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step();
        check("full_retire_ready", 64'(in_ready), 64'd1);
        check("full_retire_head", 64'(out_data), 64'h22);
        step();
        check("oor_data", 64'(out_data), 64'(DEF));
        check("oor_sel", 64'(out_sel), 64'd3);
        check("oor_valid", 64'(out_valid), 64'd1);
`ifdef MUX_NX1_PIPE_ERR_EN
        check("oor_err_sel", 64'(err_sel), 64'd1);
        check("oor_err_cnt", 64'(err_cnt), 64'd1);
`endif
        in_valid = 1'b0;
        step();
        check("bp_drained", 64'(out_valid), 64'd0);

        // Streaming: 100 back-to-back requests, one output per cycle.
        begin
            int base;
            base = n_retired;
            for (int i = 0; i < 100; i++) begin
                check("stream_in_ready", 64'(in_ready), 64'd1);
                if (i > 0) check("stream_out_valid", 64'(out_valid), 64'd1);
                in_data = {$urandom, $urandom, $urandom};
                in_sel = 2'($urandom_range(0, 2));
                in_valid = 1'b1;
                step();
            end
            in_valid = 1'b0;
            step();
            check("stream_count", 64'(n_retired - base), 64'd100);
            check("stream_empty", 64'(out_valid), 64'd0);
        end

        // Randomized traffic with random back-pressure and out-of-range selects.
        for (int i = 0; i < 400; i++) begin
            in_data = {$urandom, $urandom, $urandom};
            in_sel = 2'($urandom_range(0, 3));
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        check("random_drained", 64'(exp_q.size()), 64'd0);

        // Saturation of the error counter.
        in_sel = 2'd3; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) step();
        in_valid = 1'b0;
        repeat (2) step();
`ifdef MUX_NX1_PIPE_ERR_EN
        check("err_cnt_sat", 64'(err_cnt), 64'd255);
        check("err_cnt_model", 64'(err_cnt), 64'(model_err));
`endif
        check("oor_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-flight discards both held entries.
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd1;
        in_data = {32'h3, 32'h2, 32'h1};
        repeat (2) step();
        in_valid = 1'b0;
        check("pre_rst_ready", 64'(in_ready), 64'd0);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("post_rst_ready", 64'(in_ready), 64'd1);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        repeat (3) step();
        check("post_rst_no_stale", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
